// File: rtl/sram_pkg.sv
// ============================================================================
// Module   : sram_pkg
// Purpose  : Shared widths and word/address types for the 256x8 SRAM slice.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : sram_pkg

`default_nettype wire

// File: rtl/sram_parity.sv
// ============================================================================
// Module   : sram_parity
// Purpose  : Combinational even-parity generator over one memory word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_parity
  import sram_pkg::*;
(
  input  word_t data_i,
  output logic  par_o
);

  // Even parity: the extra bit makes the total count of ones even.
  assign par_o = ^data_i;

endmodule : sram_parity

`default_nettype wire

// File: rtl/sram_256x8.sv
// ============================================================================
// Module   : sram_256x8
// Purpose  : Single-port synchronous SRAM, 256x8, registered read data.
//            Optional stored-parity check enabled by macro SRAM_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_256x8 #(
  parameter int DATA_W = sram_pkg::DATA_W,
  parameter int ADDR_W = sram_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              WE,
  input  logic              RD,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
`ifdef SRAM_PARITY_EN
  input  logic              PINJ,
  output logic              PERR,
`endif
  output logic [DATA_W-1:0] DataOut
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              wr_en;
  logic              rd_en;

  // A simultaneous write and read request is treated as a write only.
  assign wr_en  = CS & WE;
  assign rd_en  = CS & RD & ~WE;
  assign dout_d = mem_q[Addr];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[Addr] <= DataIn;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= dout_d;
    end
  end

  assign DataOut = dout_q;

`ifdef SRAM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic wr_par;
  logic rd_par;
  logic perr_q;
  logic perr_d;

  sram_parity u_wr_parity (
    .data_i (DataIn),
    .par_o  (wr_par)
  );

  sram_parity u_rd_parity (
    .data_i (dout_d),
    .par_o  (rd_par)
  );

  // PINJ flips the stored bit so a later read reports a parity error.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      par_mem_q[Addr] <= wr_par ^ PINJ;
    end
  end

  assign perr_d = rd_par ^ par_mem_q[Addr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perr_q <= 1'b0;
    end else if (rd_en) begin
      perr_q <= perr_d;
    end
  end

  assign PERR = perr_q;
`endif

endmodule : sram_256x8

`default_nettype wire

// File: tb/tb_sram_256x8.sv
// ============================================================================
// Module   : tb_sram_256x8
// Purpose  : Directed table-driven bench for sram_256x8 (SRAM_PARITY_EN aware).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_256x8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CS = 1'b0;
  logic       WE = 1'b0;
  logic       RD = 1'b0;
  logic [7:0] Addr = 8'h00;
  logic [7:0] DataIn = 8'h00;
  logic [7:0] DataOut;
  logic       PINJ = 1'b0;
  logic       PERR;

  int checks = 0;
  int passed = 0;

  sram_256x8 dut (
    .CLK     (CLK),
    .RST     (RST),
    .CS      (CS),
    .WE      (WE),
    .RD      (RD),
    .Addr    (Addr),
    .DataIn  (DataIn),
`ifdef SRAM_PARITY_EN
    .PINJ    (PINJ),
    .PERR    (PERR),
`endif
    .DataOut (DataOut)
  );

`ifndef SRAM_PARITY_EN
  assign PERR = 1'b0;
`endif

  always #10 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       cs;
    logic       we;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic       pinj;
    logic [7:0] exp_dout;
    logic       exp_perr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic cs, input logic we, input logic rd,
                     input logic [7:0] addr, input logic [7:0] din, input logic pinj,
                     input logic [7:0] exp_dout, input logic exp_perr);
    vec_t v;
    v.name = name; v.cs = cs; v.we = we; v.rd = rd; v.addr = addr; v.din = din;
    v.pinj = pinj; v.exp_dout = exp_dout; v.exp_perr = exp_perr;
    tbl.push_back(v);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: DataOut got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) $display("FAIL %s: PERR got %b expected %b", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic cs, input logic we, input logic rd,
                       input logic [7:0] addr, input logic [7:0] din, input logic pinj);
    CS = cs; WE = we; RD = rd; Addr = addr; DataIn = din; PINJ = pinj;
  endtask

  initial begin
    // Write burst, then read-back with one-cycle latency.
    add("wr0", 1, 1, 0, 8'd0, 8'h00, 0, 8'h00, 0);
    add("wr1", 1, 1, 0, 8'd1, 8'h01, 0, 8'h00, 0);
    add("wr2", 1, 1, 0, 8'd2, 8'h0A, 0, 8'h00, 0);
    add("wr3", 1, 1, 0, 8'd3, 8'h14, 0, 8'h00, 0);
    add("wr4", 1, 1, 0, 8'd4, 8'h1E, 0, 8'h00, 0);
    add("wr5", 1, 1, 0, 8'd5, 8'h28, 0, 8'h00, 0);
    add("rd0", 1, 0, 1, 8'd0, 8'h00, 0, 8'h00, 0);
    add("rd1", 1, 0, 1, 8'd1, 8'h00, 0, 8'h01, 0);
    add("rd2", 1, 0, 1, 8'd2, 8'h00, 0, 8'h0A, 0);
    add("rd3", 1, 0, 1, 8'd3, 8'h00, 0, 8'h14, 0);
    add("rd4", 1, 0, 1, 8'd4, 8'h00, 0, 8'h1E, 0);
    add("rd5", 1, 0, 1, 8'd5, 8'h00, 0, 8'h28, 0);
    // Blocked write with CS low.
    add("cs0_wr", 0, 1, 0, 8'd2, 8'hFF, 0, 8'h28, 0);
    add("rd2_blk", 1, 0, 1, 8'd2, 8'h00, 0, 8'h0A, 0);
    add("rd5_again", 1, 0, 1, 8'd5, 8'h00, 0, 8'h28, 0);
    // Write wins over read, no write-through.
    add("we_rd_both", 1, 1, 1, 8'd3, 8'h55, 0, 8'h28, 0);
    add("rd3_new", 1, 0, 1, 8'd3, 8'h00, 0, 8'h55, 0);
    // Idle cycles hold the last read value.
    add("rd4_1e", 1, 0, 1, 8'd4, 8'h00, 0, 8'h1E, 0);
    add("idle_a0", 1, 0, 0, 8'd0, 8'h00, 0, 8'h1E, 0);
    add("idle_a9", 1, 0, 0, 8'd9, 8'h00, 0, 8'h1E, 0);
    add("cs0_rd", 0, 0, 1, 8'd1, 8'h00, 0, 8'h1E, 0);
    // Read immediately after write, then back-to-back reads.
    add("wr6", 1, 1, 0, 8'd6, 8'h77, 0, 8'h1E, 0);
    add("rd6", 1, 0, 1, 8'd6, 8'h00, 0, 8'h77, 0);
    add("b2b1", 1, 0, 1, 8'd1, 8'h00, 0, 8'h01, 0);
    add("b2b2", 1, 0, 1, 8'd2, 8'h00, 0, 8'h0A, 0);
    add("b2b3", 1, 0, 1, 8'd3, 8'h00, 0, 8'h55, 0);
    // Parity sequence (data path checked in every build).
    add("wr7", 1, 1, 0, 8'd7, 8'hA5, 0, 8'h55, 0);
    add("wr8_inj", 1, 1, 0, 8'd8, 8'hA5, 1, 8'h55, 0);
    add("rd7", 1, 0, 1, 8'd7, 8'h00, 0, 8'hA5, 0);
    add("rd8", 1, 0, 1, 8'd8, 8'h00, 0, 8'hA5, 1);
    add("perr_hold", 1, 0, 0, 8'd7, 8'h00, 0, 8'hA5, 1);
    add("rd7_clr", 1, 0, 1, 8'd7, 8'h00, 0, 8'hA5, 0);
    add("rd255_wr", 1, 1, 0, 8'd255, 8'hC3, 0, 8'hA5, 0);
    add("rd255", 1, 0, 1, 8'd255, 8'h00, 0, 8'hC3, 0);

    // Asynchronous reset at time zero, before any clock edge.
    #1;
    check8("reset_async", DataOut, 8'h00);
`ifdef SRAM_PARITY_EN
    check1("reset_perr", PERR, 1'b0);
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i].cs, tbl[i].we, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].pinj);
      @(posedge CLK);
      #1;
      check8(tbl[i].name, DataOut, tbl[i].exp_dout);
`ifdef SRAM_PARITY_EN
      check1(tbl[i].name, PERR, tbl[i].exp_perr);
`endif
    end

    // Mid-test reset: DataOut forced to 0 between edges, held while RST high.
    @(negedge CLK);
    drive(1, 0, 1, 8'd4, 8'h00, 0);
    @(posedge CLK);
    #1;
    check8("pre_reset_rd4", DataOut, 8'h1E);
    #4;
    RST = 1'b1;
    #1;
    check8("mid_reset_async", DataOut, 8'h00);
    @(posedge CLK);
    #1;
    check8("reset_held_rd", DataOut, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    drive(1, 0, 0, 8'd4, 8'h00, 0);
    @(posedge CLK);
    #1;
    check8("post_reset_idle", DataOut, 8'h00);
    @(negedge CLK);
    drive(1, 0, 1, 8'd4, 8'h00, 0);
    @(posedge CLK);
    #1;
    check8("post_reset_rd4", DataOut, 8'h1E);
    @(negedge CLK);
    drive(0, 0, 0, 8'd0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_sram_256x8

`default_nettype wire
